hazard_ctrl: RTL and testbench



---
 rtl/hazard_pkg.sv | 20 ++
 rtl/md_busy_ctr.sv | 37 +++
 rtl/hazard_ctrl.sv | 150 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and helpers for the pipeline hazard/forwarding controller.
package hazard_pkg;

    localparam int REG_W = 5;

    typedef enum logic [2:0] {
        NONE,
        HOLD,
        FLUSH,
        MD,
        LOAD,
        BR
    } stall_e;

    // Width of a value range 0..n, never narrower than one bit.
    function automatic int sel_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/md_busy_ctr.sv
// Mul/div in-flight counter: loads the unit latency on issue, counts down,
// and is killed by an exception flush (with a one-cycle abort to the unit).
module md_busy_ctr
    import hazard_pkg::*;
#(
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 33
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic is_div,
    input  logic flush,
    output logic busy,
    output logic abort
);

    localparam int CW = sel_w(DIV_LAT);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (flush) begin
            cnt <= '0;
        end else if (start) begin
            cnt <= is_div ? CW'(DIV_LAT) : CW'(MUL_LAT);
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign busy  = (cnt != '0);
    assign abort = flush & busy;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and forwarding controller beside the ID stage.
// Optional per-cause stall counters: define HAZARD_PERF_EN.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int NUM_FWD  = 2,
    parameter int MUL_LAT  = 4,
    parameter int DIV_LAT  = 33,
    parameter int RST_HOLD = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     id_valid,
    input  logic [REG_W-1:0]         id_rs,
    input  logic [REG_W-1:0]         id_rt,
    input  logic                     id_rs_use,
    input  logic                     id_rt_use,
    input  logic                     id_bj,
    input  logic                     id_hilo_rd,
    input  logic                     id_md_start,
    input  logic                     id_md_div,
    input  logic [NUM_FWD-1:0]       fwd_wr,
    input  logic [REG_W*NUM_FWD-1:0] fwd_rd,
    input  logic [NUM_FWD-1:0]       fwd_late,
    input  logic                     ex_flush,
    output logic [sel_w(NUM_FWD)-1:0] rs_sel,
    output logic [sel_w(NUM_FWD)-1:0] rt_sel,
    output logic                     pc_wr,
    output logic                     if_id_wr,
    output logic                     bubble,
    output logic                     inst_req_en,
    output logic                     md_busy,
    output logic                     md_abort
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]              perf_md,
    output logic [31:0]              perf_load,
    output logic [31:0]              perf_br,
    output logic [31:0]              perf_hold
`endif
);

    localparam int SW = sel_w(NUM_FWD);
    localparam int HW = sel_w(RST_HOLD);

    logic [NUM_FWD-1:0] m_rs;
    logic [NUM_FWD-1:0] m_rt;
    logic [SW-1:0]      rs_win;
    logic [SW-1:0]      rt_win;
    logic               rs_late;
    logic               rt_late;
    logic [HW-1:0]      hold_cnt;
    logic               hold_act;
    logic               stall;
    logic               md_start;
    stall_e             cause;

    for (genvar k = 0; k < NUM_FWD; k++) begin : g_fwd
        logic [REG_W-1:0] rd;
        assign rd      = fwd_rd[REG_W*k +: REG_W];
        assign m_rs[k] = fwd_wr[k] && (rd != '0) &&
                         (rd == id_rs) && id_rs_use;
        assign m_rt[k] = fwd_wr[k] && (rd != '0) &&
                         (rd == id_rt) && id_rt_use;
    end

    // Walk oldest to youngest so the youngest match is written last.
    always_comb begin
        rs_win  = '0;
        rt_win  = '0;
        rs_late = 1'b0;
        rt_late = 1'b0;
        for (int k = NUM_FWD - 1; k >= 0; k--) begin
            if (m_rs[k]) begin
                rs_win  = SW'(k + 1);
                rs_late = fwd_late[k];
            end
            if (m_rt[k]) begin
                rt_win  = SW'(k + 1);
                rt_late = fwd_late[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt <= HW'(RST_HOLD);
        end else if (hold_cnt != '0) begin
            hold_cnt <= hold_cnt - 1'b1;
        end
    end

    assign hold_act = !rst_n || (hold_cnt != '0);

    always_comb begin
        cause = NONE;
        if (hold_act) begin
            cause = HOLD;
        end else if (id_valid && ex_flush) begin
            cause = FLUSH;
        end else if (id_valid && md_busy && (id_hilo_rd || id_md_start)) begin
            cause = MD;
        end else if (id_valid && (rs_late || rt_late)) begin
            cause = LOAD;
        end else if (id_valid && id_bj && (m_rs[0] || m_rt[0])) begin
            cause = BR;
        end
    end

    assign stall = (cause == HOLD) || (cause == MD) ||
                   (cause == LOAD) || (cause == BR);

    assign pc_wr       = !stall;
    assign if_id_wr    = !stall;
    assign inst_req_en = !stall;
    assign bubble      = stall;
    assign rs_sel      = hold_act ? '0 : rs_win;
    assign rt_sel      = hold_act ? '0 : rt_win;
    assign md_start    = id_valid && id_md_start && !stall;

    md_busy_ctr #(
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT)
    ) u_md (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (md_start),
        .is_div (id_md_div),
        .flush  (ex_flush),
        .busy   (md_busy),
        .abort  (md_abort)
    );

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_md   <= '0;
            perf_load <= '0;
            perf_br   <= '0;
            perf_hold <= '0;
        end else begin
            if (cause == MD)   perf_md   <= perf_md + 32'd1;
            if (cause == LOAD) perf_load <= perf_load + 32'd1;
            if (cause == BR)   perf_br   <= perf_br + 32'd1;
            if (cause == HOLD) perf_hold <= perf_hold + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (NUM_FWD=2, RST_HOLD=3).
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_rs_use;
    logic       id_rt_use;
    logic       id_bj;
    logic       id_hilo_rd;
    logic       id_md_start;
    logic       id_md_div;
    logic [1:0] fwd_wr;
    logic [9:0] fwd_rd;
    logic [1:0] fwd_late;
    logic       ex_flush;
    logic [1:0] rs_sel;
    logic [1:0] rt_sel;
    logic       pc_wr;
    logic       if_id_wr;
    logic       bubble;
    logic       inst_req_en;
    logic       md_busy;
    logic       md_abort;
`ifdef HAZARD_PERF_EN
    logic [31:0] perf_md;
    logic [31:0] perf_load;
    logic [31:0] perf_br;
    logic [31:0] perf_hold;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int n;

    always #5 clk = ~clk;

    hazard_ctrl #(
        .NUM_FWD  (2),
        .MUL_LAT  (4),
        .DIV_LAT  (33),
        .RST_HOLD (3)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_valid    (id_valid),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_rs_use   (id_rs_use),
        .id_rt_use   (id_rt_use),
        .id_bj       (id_bj),
        .id_hilo_rd  (id_hilo_rd),
        .id_md_start (id_md_start),
        .id_md_div   (id_md_div),
        .fwd_wr      (fwd_wr),
        .fwd_rd      (fwd_rd),
        .fwd_late    (fwd_late),
        .ex_flush    (ex_flush),
        .rs_sel      (rs_sel),
        .rt_sel      (rt_sel),
        .pc_wr       (pc_wr),
        .if_id_wr    (if_id_wr),
        .bubble      (bubble),
        .inst_req_en (inst_req_en),
        .md_busy     (md_busy),
        .md_abort    (md_abort)
`ifdef HAZARD_PERF_EN
        ,
        .perf_md     (perf_md),
        .perf_load   (perf_load),
        .perf_br     (perf_br),
        .perf_hold   (perf_hold)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_ctl(input string tag, input bit stl);
        chk({tag, ".pc_wr"}, 32'(pc_wr), 32'(!stl));
        chk({tag, ".if_id_wr"}, 32'(if_id_wr), 32'(!stl));
        chk({tag, ".bubble"}, 32'(bubble), 32'(stl));
        chk({tag, ".inst_req_en"}, 32'(inst_req_en), 32'(!stl));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        id_valid    = 1'b0;
        id_rs       = '0;
        id_rt       = '0;
        id_rs_use   = 1'b0;
        id_rt_use   = 1'b0;
        id_bj       = 1'b0;
        id_hilo_rd  = 1'b0;
        id_md_start = 1'b0;
        id_md_div   = 1'b0;
        fwd_wr      = '0;
        fwd_rd      = '0;
        fwd_late    = '0;
        ex_flush    = 1'b0;
    endtask

    initial begin
        clr();
        rst_n = 1'b0;
        // reset state, with a live forward match that must stay masked
        fwd_wr    = 2'b11;
        fwd_rd    = {5'd8, 5'd8};
        id_rs     = 5'd8;
        id_rs_use = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_ctl("rst", 1'b1);
        chk("rst.rs_sel", 32'(rs_sel), 32'd0);
        chk("rst.rt_sel", 32'(rt_sel), 32'd0);
        chk("rst.md_busy", 32'(md_busy), 32'd0);
        chk("rst.md_abort", 32'(md_abort), 32'd0);

        // three hold cycles after release, then run
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_ctl("hold0", 1'b1);
        chk("hold0.rs_sel", 32'(rs_sel), 32'd0);
        tick();
        chk_ctl("hold1", 1'b1);
        tick();
        chk_ctl("hold2", 1'b1);
        chk("hold2.rs_sel", 32'(rs_sel), 32'd0);
        tick();
        chk_ctl("hold_done", 1'b0);

        // both stages write r8: youngest wins
        id_valid = 1'b1;
        #1;
        chk("fwd_young.rs_sel", 32'(rs_sel), 32'd1);
        chk_ctl("fwd_young", 1'b0);

        // load-use on rt, then load moves to stage 1
        clr();
        id_valid  = 1'b1;
        fwd_wr    = 2'b01;
        fwd_rd    = {5'd0, 5'd5};
        fwd_late  = 2'b01;
        id_rt     = 5'd5;
        id_rt_use = 1'b1;
        #1;
        chk_ctl("ld_use", 1'b1);
        tick();
        fwd_wr   = 2'b10;
        fwd_rd   = {5'd5, 5'd0};
        fwd_late = 2'b00;
        #1;
        chk("ld_next.rt_sel", 32'(rt_sel), 32'd2);
        chk_ctl("ld_next", 1'b0);

        // older late stage shadowed by younger match
        fwd_wr   = 2'b11;
        fwd_rd   = {5'd5, 5'd5};
        fwd_late = 2'b10;
        #1;
        chk("shadow.rt_sel", 32'(rt_sel), 32'd1);
        chk_ctl("shadow", 1'b0);

        // branch in ID vs stage-0 producer
        clr();
        id_valid  = 1'b1;
        id_bj     = 1'b1;
        fwd_wr    = 2'b01;
        fwd_rd    = {5'd0, 5'd3};
        id_rs     = 5'd3;
        id_rs_use = 1'b1;
        #1;
        chk_ctl("br", 1'b1);
        id_rs_use = 1'b0;
        #1;
        chk_ctl("br_nouse", 1'b0);
        chk("br_nouse.rs_sel", 32'(rs_sel), 32'd0);
        fwd_rd    = {5'd0, 5'd0};
        id_rs     = 5'd0;
        id_rs_use = 1'b1;
        #1;
        chk_ctl("br_r0", 1'b0);
        chk("br_r0.rs_sel", 32'(rs_sel), 32'd0);
        id_valid  = 1'b0;
        fwd_rd    = {5'd0, 5'd3};
        id_rs     = 5'd3;
        #1;
        chk_ctl("br_invalid", 1'b0);

        // divide then mfhi: 33 stall cycles
        clr();
        id_valid    = 1'b1;
        id_md_start = 1'b1;
        id_md_div   = 1'b1;
        #1;
        chk("div_issue.md_busy", 32'(md_busy), 32'd0);
        chk_ctl("div_issue", 1'b0);
        tick();
        id_md_start = 1'b0;
        id_md_div   = 1'b0;
        id_hilo_rd  = 1'b1;
        #1;
        chk("div_t1.md_busy", 32'(md_busy), 32'd1);
        n = 0;
        while (pc_wr !== 1'b1 && n < 60) begin
            n++;
            tick();
        end
        chk("div_stall_cycles", 32'(n), 32'd33);
        chk("div_done.md_busy", 32'(md_busy), 32'd0);

        // mult then a second mult: blocked 4 cycles, then loads
        clr();
        id_valid    = 1'b1;
        id_md_start = 1'b1;
        tick();
        #1;
        chk("mul_t1.md_busy", 32'(md_busy), 32'd1);
        n = 0;
        while (pc_wr !== 1'b1 && n < 20) begin
            n++;
            tick();
        end
        chk("mul_stall_cycles", 32'(n), 32'd4);
        tick();
        chk("mul2_loaded.md_busy", 32'(md_busy), 32'd1);
        clr();
        repeat (4) tick();
        chk("mul2_done.md_busy", 32'(md_busy), 32'd0);

        // flush at counter 10 with a load-use present
        id_valid    = 1'b1;
        id_md_start = 1'b1;
        id_md_div   = 1'b1;
        tick();
        clr();
        repeat (23) tick();
        id_valid   = 1'b1;
        id_hilo_rd = 1'b1;
        fwd_wr     = 2'b01;
        fwd_rd     = {5'd0, 5'd5};
        fwd_late   = 2'b01;
        id_rt      = 5'd5;
        id_rt_use  = 1'b1;
        ex_flush   = 1'b1;
        #1;
        chk("flush.md_abort", 32'(md_abort), 32'd1);
        chk("flush.md_busy", 32'(md_busy), 32'd1);
        chk_ctl("flush", 1'b0);
        tick();
        ex_flush = 1'b0;
        #1;
        chk("post_flush.md_busy", 32'(md_busy), 32'd0);
        chk("post_flush.md_abort", 32'(md_abort), 32'd0);
        chk_ctl("post_flush", 1'b1);
        clr();
        ex_flush = 1'b1;
        #1;
        chk("flush_idle.md_abort", 32'(md_abort), 32'd0);
        clr();

`ifdef HAZARD_PERF_EN
        chk("perf_hold", perf_hold, 32'd3);
`endif

        // reset mid-divide
        id_valid    = 1'b1;
        id_md_start = 1'b1;
        id_md_div   = 1'b1;
        tick();
        clr();
        #1;
        chk("rst_div.pre_busy", 32'(md_busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_div.md_busy", 32'(md_busy), 32'd0);
        chk("rst_div.md_abort", 32'(md_abort), 32'd0);
        chk_ctl("rst_div", 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
